keystone_csr_axil: RTL

AXI4-Lite responder that owns the keystone correction block's control/status registers. Sits between the processor's AXI4-Lite interconnect and the keystone wrapper. Decodes single-beat reads and writes into an enable bit, a self-clearing soft-reset pulse, a read-only status word and a bank of mapping-coefficient registers. The mapping registers are presented to the wrapper as one flat vector.

---
 rtl/keystone_csr_axil.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/keystone_csr_axil.sv
// AXI4-Lite control/status register block for the keystone correction wrapper.
// Holds the enable bit, a one-cycle soft-reset pulse, a status window and the mapping coefficients.
module keystone_csr_axil #(
    parameter int ADDR_WIDTH = 6,
    parameter int NUM_REGS   = 12
) (
    input  logic                       aclk,
    input  logic                       aresetn,
    input  logic [ADDR_WIDTH-1:0]      s_axil_awaddr,
    input  logic                       s_axil_awvalid,
    output logic                       s_axil_awready,
    input  logic [31:0]                s_axil_wdata,
    input  logic [3:0]                 s_axil_wstrb,
    input  logic                       s_axil_wvalid,
    output logic                       s_axil_wready,
    output logic [1:0]                 s_axil_bresp,
    output logic                       s_axil_bvalid,
    input  logic                       s_axil_bready,
    input  logic [ADDR_WIDTH-1:0]      s_axil_araddr,
    input  logic                       s_axil_arvalid,
    output logic                       s_axil_arready,
    output logic [31:0]                s_axil_rdata,
    output logic [1:0]                 s_axil_rresp,
    output logic                       s_axil_rvalid,
    input  logic                       s_axil_rready,
    input  logic [31:0]                status_in,
    output logic                       sw_en,
    output logic                       sw_rst,
    output logic [32*(NUM_REGS-2)-1:0] map_regs_out
);

    localparam int          NUM_MAP     = NUM_REGS - 2;
    localparam logic [31:0] NUM_REGS_W  = 32'(NUM_REGS);
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_ACCEPT, W_RESP} wstate_t;
    typedef enum logic [1:0] {R_IDLE, R_ACCEPT, R_DATA} rstate_t;

    wstate_t     wstate_q, wstate_d;
    rstate_t     rstate_q, rstate_d;
    logic [1:0]  bresp_q, bresp_d;
    logic [1:0]  rresp_q, rresp_d;
    logic [31:0] rdata_q, rdata_d;
    logic        sw_en_q, sw_en_d;
    logic        sw_rst_q, sw_rst_d;
    logic [31:0] map_q [NUM_MAP];
    logic [31:0] map_d [NUM_MAP];

    logic [31:0] w_idx;
    logic [31:0] r_idx;
    logic        unused_addr_lsbs;

    // Byte offset within a word is don't-care; only the word index decodes.
    assign w_idx            = 32'(s_axil_awaddr[ADDR_WIDTH-1:2]);
    assign r_idx            = 32'(s_axil_araddr[ADDR_WIDTH-1:2]);
    assign unused_addr_lsbs = ^{s_axil_awaddr[1:0], s_axil_araddr[1:0]};

    // Write path: the address and data are still held by the master in W_ACCEPT,
    // so the commit reads them straight off the bus.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        wstate_d = wstate_q;
        bresp_d  = bresp_q;
        sw_en_d  = sw_en_q;
        sw_rst_d = 1'b0;
        map_d    = map_q;
        case (wstate_q)
            W_IDLE: begin
                if (s_axil_awvalid && s_axil_wvalid) begin
                    wstate_d = W_ACCEPT;
                end
            end
            W_ACCEPT: begin
                wstate_d = W_RESP;
                if (w_idx >= NUM_REGS_W || w_idx == 32'd1) begin
                    bresp_d = RESP_SLVERR;
                end else begin
                    bresp_d = RESP_OKAY;
                    if (w_idx == 32'd0 && s_axil_wstrb[0]) begin
                        sw_en_d  = s_axil_wdata[0];
                        sw_rst_d = s_axil_wdata[1];
                    end
                    for (int i = 0; i < NUM_MAP; i++) begin
                        if (w_idx == 32'(i + 2)) begin
                            for (int k = 0; k < 4; k++) begin
                                if (s_axil_wstrb[k]) begin
                                    map_d[i][8*k +: 8] = s_axil_wdata[8*k +: 8];
                                end
                            end
                        end
                    end
                end
            end
            W_RESP: begin
                if (s_axil_bready) begin
                    wstate_d = W_IDLE;
                end
            end
            default: wstate_d = W_IDLE;
        endcase
    end

    // Read path samples the current register state, so a same-edge write is not yet visible.
    always_comb begin
        rstate_d = rstate_q;
        rdata_d  = rdata_q;
        rresp_d  = rresp_q;
        case (rstate_q)
            R_IDLE: begin
                if (s_axil_arvalid) begin
                    rstate_d = R_ACCEPT;
                end
            end
            R_ACCEPT: begin
                rstate_d = R_DATA;
                rresp_d  = RESP_OKAY;
                rdata_d  = '0;
                if (r_idx >= NUM_REGS_W) begin
                    rresp_d = RESP_SLVERR;
                end else if (r_idx == 32'd0) begin
                    rdata_d = {31'b0, sw_en_q};
                end else if (r_idx == 32'd1) begin
                    rdata_d = status_in;
                end else begin
                    for (int i = 0; i < NUM_MAP; i++) begin
                        if (r_idx == 32'(i + 2)) begin
                            rdata_d = map_q[i];
                        end
                    end
                end
            end
            R_DATA: begin
                if (s_axil_rready) begin
                    rstate_d = R_IDLE;
                end
            end
            default: rstate_d = R_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
        if (!aresetn) begin
            wstate_q <= W_IDLE;
            rstate_q <= R_IDLE;
            bresp_q  <= RESP_OKAY;
            rresp_q  <= RESP_OKAY;
            rdata_q  <= '0;
            sw_en_q  <= 1'b0;
            sw_rst_q <= 1'b0;
            // NOTE: the coefficient bank is software-visible state, so it is reset like any register.
            map_q    <= '{default: '0};
        end else begin
            wstate_q <= wstate_d;
            rstate_q <= rstate_d;
            bresp_q  <= bresp_d;
            rresp_q  <= rresp_d;
            rdata_q  <= rdata_d;
            sw_en_q  <= sw_en_d;
            sw_rst_q <= sw_rst_d;
            map_q    <= map_d;
        end
    end

    assign s_axil_awready = (wstate_q == W_ACCEPT);
    assign s_axil_wready  = (wstate_q == W_ACCEPT);
    assign s_axil_bvalid  = (wstate_q == W_RESP);
    assign s_axil_bresp   = bresp_q;
    assign s_axil_arready = (rstate_q == R_ACCEPT);
    assign s_axil_rvalid  = (rstate_q == R_DATA);
    assign s_axil_rdata   = rdata_q;
    assign s_axil_rresp   = rresp_q;
    assign sw_en          = sw_en_q;
    assign sw_rst         = sw_rst_q;

    always_comb begin
        map_regs_out = '0;
        for (int i = 0; i < NUM_MAP; i++) begin
            map_regs_out[32*i +: 32] = map_q[i];
        end
    end

endmodule
